// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD,
    ST_DRAIN,
    ST_HALTED
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0080;
  localparam int unsigned DEF_PC_STEP      = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_slot_t;

  function automatic logic misaligned(
    input logic [1:0] lsb
  );
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC / EPC priority mux: trap, misaligned redirect,
// redirect, then sequential advance.
module pc_next_sel
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
  parameter int unsigned PC_STEP     = DEF_PC_STEP
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] epc_i,
  input  logic        trap_i,
  input  logic        redir_valid_i,
  input  logic [31:0] redir_target_i,
  input  logic        advance_i,
  output logic [31:0] pc_o,
  output logic [31:0] epc_o
);

  localparam logic [31:0] STEP = 32'(PC_STEP);

  logic bad_target;

  assign bad_target = redir_valid_i
    && misaligned(redir_target_i[1:0]);

  always_comb begin
    pc_o  = pc_i;
    epc_o = epc_i;
    if (trap_i) begin
      epc_o = pc_i;
      pc_o  = TRAP_VECTOR;
    end else if (bad_target) begin
      epc_o = redir_target_i;
      pc_o  = TRAP_VECTOR;
    end else if (redir_valid_i) begin
      pc_o = redir_target_i;
    end else if (advance_i) begin
      pc_o = pc_i + STEP;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, issues one imem request at a
// time and hands instructions to decode via valid/ready.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
  parameter int unsigned PC_STEP      = DEF_PC_STEP
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic        Trap,
  input  logic        Halt,
  input  logic        Resume,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemValid,
  input  logic [31:0] ImemData,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  input  logic        DecodeReady,
  output logic [31:0] PC,
  output logic [31:0] EPC,
  output logic        Halted
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  fetch_slot_t slot_q, slot_d;
  logic        flush;
  logic        advance;

  assign flush = Trap | RedirectValid;

  pc_next_sel #(
    .TRAP_VECTOR (TRAP_VECTOR),
    .PC_STEP     (PC_STEP)
  ) u_pc_next_sel (
    .pc_i           (pc_q),
    .epc_i          (epc_q),
    .trap_i         (Trap),
    .redir_valid_i  (RedirectValid),
    .redir_target_i (RedirectTarget),
    .advance_i      (advance),
    .pc_o           (pc_d),
    .epc_o          (epc_d)
  );

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    advance = 1'b0;
    ImemReq = 1'b0;
    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (!flush) begin
          ImemReq = 1'b1;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // a redirect racing the response drops it on the floor
        if (flush) begin
          state_d = ImemValid ? ST_REQ : ST_DRAIN;
        end else if (ImemValid) begin
          slot_d.instr = ImemData;
          slot_d.pc    = pc_q;
          state_d      = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          state_d = ST_REQ;
        end else if (DecodeReady) begin
          advance = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (ImemValid) state_d = ST_REQ;
      end
      ST_HALTED: begin
        if (Resume) state_d = ST_REQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_VECTOR;
      epc_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      slot_q  <= slot_d;
    end
  end

  assign ImemAddr   = pc_q;
  assign InstrValid = (state_q == ST_HOLD);
  assign Instr      = slot_q.instr;
  assign InstrPC    = slot_q.pc;
  assign PC         = pc_q;
  assign EPC        = epc_q;
  assign Halted     = (state_q == ST_HALTED);

endmodule
